// File: rtl/airi5c_itof_converter.sv
// Integer to binary32 converter (fcvt.s.w / fcvt.s.wu): two-stage pipeline
// with the rounding logic working directly on the stage-2 registers.
module airi5c_itof_converter (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        kill,
    input  logic        load,
    input  logic        op_cvtif,
    input  logic        op_cvtuf,
    input  logic [2:0]  rm,
    input  logic [31:0] int_in,
    output logic [31:0] float_out,
    output logic        IE,
    output logic        ready
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MAN_W = 24;
    localparam int unsigned LZ_W  = 5;

    localparam logic [2:0] FPU_RM_RTZ = 3'b001;
    localparam logic [2:0] FPU_RM_RDN = 3'b010;
    localparam logic [2:0] FPU_RM_RUP = 3'b011;
    localparam logic [2:0] FPU_RM_RMM = 3'b100;

    // stage 1
    logic              v1;
    logic              sgn1;
    logic [XLEN-1:0]   mag1;
    logic [2:0]        rm1;
    logic              zero1;

    // stage 2
    logic              v2;
    logic              sgn2;
    logic [7:0]        exp2;
    logic [MAN_W-1:0]  man2;
    logic              round2;
    logic              sticky2;
    logic [2:0]        rm2;
    logic              zero2;

    logic [LZ_W-1:0]   lz;
    logic [XLEN-1:0]   norm;
    logic              clear;
    logic              sgn_in;

    logic              round_up;
    logic [MAN_W:0]    man_rnd;

    assign clear  = kill || (load && !op_cvtif && !op_cvtuf);
    assign sgn_in = op_cvtif & int_in[31];
    assign ready  = v2;

    // Leading-zero count of the stage-1 magnitude; the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (mag1[i]) lz = LZ_W'(XLEN - 1 - i);
        end
        norm = mag1 << lz;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v1      <= 1'b0;
            sgn1    <= 1'b0;
            mag1    <= '0;
            rm1     <= '0;
            zero1   <= 1'b0;
            v2      <= 1'b0;
            sgn2    <= 1'b0;
            exp2    <= '0;
            man2    <= '0;
            round2  <= 1'b0;
            sticky2 <= 1'b0;
            rm2     <= '0;
            zero2   <= 1'b0;
        end else if (clear) begin
            v1      <= 1'b0;
            sgn1    <= 1'b0;
            mag1    <= '0;
            rm1     <= '0;
            zero1   <= 1'b0;
            v2      <= 1'b0;
            sgn2    <= 1'b0;
            exp2    <= '0;
            man2    <= '0;
            round2  <= 1'b0;
            sticky2 <= 1'b0;
            rm2     <= '0;
            zero2   <= 1'b0;
        end else if (load) begin
            // A new load abandons anything older still in flight.
            v1    <= 1'b1;
            sgn1  <= sgn_in;
            mag1  <= sgn_in ? (~int_in + XLEN'(1)) : int_in;
            rm1   <= rm;
            zero1 <= (int_in == '0);
            v2    <= 1'b0;
        end else begin
            v1 <= 1'b0;
            v2 <= v1;
            if (v1) begin
                sgn2    <= sgn1;
                exp2    <= 8'd158 - 8'(lz);
                man2    <= norm[31:8];
                round2  <= norm[7];
                sticky2 <= |norm[6:0];
                rm2     <= rm1;
                zero2   <= zero1;
            end
        end
    end

    // Rounding decision; unused encodings fall back to RNE.
    always_comb begin
        case (rm2)
            FPU_RM_RTZ: round_up = 1'b0;
            FPU_RM_RDN: round_up = sgn2 & (round2 | sticky2);
            FPU_RM_RUP: round_up = !sgn2 & (round2 | sticky2);
            FPU_RM_RMM: round_up = round2;
            default:    round_up = round2 & (sticky2 | man2[0]);
        endcase
        man_rnd = {1'b0, man2} + (MAN_W + 1)'(round_up);
    end

    always_comb begin
        float_out = '0;
        IE        = 1'b0;
        if (!zero2) begin
            IE = round2 | sticky2;
            if (man_rnd[MAN_W])
                float_out = {sgn2, exp2 + 8'd1, 23'd0};
            else
                float_out = {sgn2, exp2, man_rnd[22:0]};
        end
    end

endmodule

// File: tb/tb_airi5c_itof_converter.sv
// Directed-vector bench for airi5c_itof_converter with hand-computed results.
module tb_airi5c_itof_converter;

    logic        clk;
    logic        n_reset;
    logic        kill;
    logic        load;
    logic        op_cvtif;
    logic        op_cvtuf;
    logic [2:0]  rm;
    logic [31:0] int_in;
    logic [31:0] float_out;
    logic        IE;
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    localparam logic [1:0] OP_S = 2'b10;
    localparam logic [1:0] OP_U = 2'b01;

    airi5c_itof_converter dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .kill      (kill),
        .load      (load),
        .op_cvtif  (op_cvtif),
        .op_cvtuf  (op_cvtuf),
        .rm        (rm),
        .int_in    (int_in),
        .float_out (float_out),
        .IE        (IE),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one load and check the result 2 cycles later; inputs change on negedges.
    task automatic convert(input string tag, input logic [1:0] op, input logic [2:0] mode,
                           input logic [31:0] val, input logic [31:0] exp_f, input logic exp_ie);
        @(negedge clk);
        load = 1'b1; {op_cvtif, op_cvtuf} = op; rm = mode; int_in = val;
        @(negedge clk);
        load = 1'b0; {op_cvtif, op_cvtuf} = 2'b00; rm = 3'b111; int_in = 32'hDEAD_BEEF;
        check({tag, ".early"}, 32'(ready), 32'd0);
        @(negedge clk);
        check({tag, ".ready"}, 32'(ready), 32'd1);
        check({tag, ".out"},   float_out,  exp_f);
        check({tag, ".ie"},    32'(IE),    32'(exp_ie));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(ready), 32'd0);
        check({tag, ".hold"},  float_out,  exp_f);
    endtask

    initial begin
        n_reset = 1'b0; kill = 1'b0; load = 1'b0;
        op_cvtif = 1'b0; op_cvtuf = 1'b0; rm = RNE; int_in = '0;
        #1;
        check("rst.out",   float_out,  32'h0);
        check("rst.ie",    32'(IE),    32'd0);
        check("rst.ready", 32'(ready), 32'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        convert("s_one",  OP_S, RNE, 32'h0000_0001, 32'h3F80_0000, 1'b0);

        // Reset in the middle of a conversion, outputs previously non-zero.
        @(negedge clk);
        load = 1'b1; op_cvtif = 1'b1; int_in = 32'h0000_0005;
        @(negedge clk);
        load = 1'b0; op_cvtif = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        check("midrst.out", float_out, 32'h0);
        check("midrst.ie",  32'(IE),   32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("midrst.ready", 32'(ready), 32'd0);
            check("midrst.hold",  float_out,  32'h0);
            @(negedge clk);
        end

        convert("s_m1",     OP_S, RNE, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
        convert("s_min",    OP_S, RNE, 32'h8000_0000, 32'hCF00_0000, 1'b0);
        convert("s_max_rne",OP_S, RNE, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1);
        convert("s_max_rtz",OP_S, RTZ, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1);
        convert("s_max_rm5",OP_S, 3'b101, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1);
        convert("u_tie_rne",OP_U, RNE, 32'h0100_0001, 32'h4B80_0000, 1'b1);
        convert("u_tie_rup",OP_U, RUP, 32'h0100_0001, 32'h4B80_0001, 1'b1);
        convert("u_tie_rtz",OP_U, RTZ, 32'h0100_0001, 32'h4B80_0000, 1'b1);
        convert("u_tie_rmm",OP_U, RMM, 32'h0100_0001, 32'h4B80_0001, 1'b1);
        convert("s_neg_rdn",OP_S, RDN, 32'hFEFF_FFFF, 32'hCB80_0001, 1'b1);
        convert("s_neg_rup",OP_S, RUP, 32'hFEFF_FFFF, 32'hCB80_0000, 1'b1);
        convert("u_max",    OP_U, RNE, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1);
        convert("u_m1_big", OP_U, RTZ, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 1'b1);
        convert("u_zero",   OP_U, RNE, 32'h0000_0000, 32'h0000_0000, 1'b0);
        convert("s_zero",   OP_S, RDN, 32'h0000_0000, 32'h0000_0000, 1'b0);
        convert("both_ops", 2'b11, RNE, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);

        // Back-to-back loads: only the second completes.
        @(negedge clk);
        load = 1'b1; op_cvtif = 1'b1; rm = RNE; int_in = 32'h0000_0001;
        @(negedge clk);
        int_in = 32'h0000_0002;
        check("b2b.first", 32'(ready), 32'd0);
        @(negedge clk);
        load = 1'b0; op_cvtif = 1'b0;
        check("b2b.early", 32'(ready), 32'd0);
        @(negedge clk);
        check("b2b.ready", 32'(ready), 32'd1);
        check("b2b.out",   float_out,  32'h4000_0000);
        @(negedge clk);
        check("b2b.pulse", 32'(ready), 32'd0);

        // Load then kill on the next edge: no ready, outputs cleared.
        @(negedge clk);
        load = 1'b1; op_cvtif = 1'b1; int_in = 32'h0000_0007;
        @(negedge clk);
        load = 1'b0; op_cvtif = 1'b0; kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("kill.ready", 32'(ready), 32'd0);
            check("kill.out",   float_out,  32'h0);
            @(negedge clk);
        end

        // Load with no op bit set behaves as a clear.
        convert("pre_inv", OP_U, RNE, 32'h0000_0003, 32'h4040_0000, 1'b0);
        @(negedge clk);
        load = 1'b1; int_in = 32'h0000_0009;
        @(negedge clk);
        load = 1'b0;
        check("inv.out", float_out, 32'h0);
        @(negedge clk);
        check("inv.ready", 32'(ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/airi5c_itof_converter.md
# airi5c_itof_converter

Converts a 32-bit signed (`fcvt.s.w`) or unsigned (`fcvt.s.wu`) integer into an IEEE-754 binary32 value, honouring all RISC-V rounding modes and reporting the inexact flag. It is the int→float counterpart of the FPU's float→int path. It sits in `airi5c_fpu` beside the other conversion units and shares their `load`/`kill`/`ready` handshake. It is a two-stage pipeline: stage 1 takes the magnitude, stage 2 normalises, and rounding is combinational on the stage-2 registers.

## Interface

Parameters: none.

- `clk`  in  1  clock. All registers update on the rising edge.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `kill`  in  1  aborts any in-flight conversion and clears all state.
- `load`  in  1  starts a conversion, sampled on the rising edge.
- `op_cvtif`  in  1  interpret `int_in` as signed two's complement.
- `op_cvtuf`  in  1  interpret `int_in` as unsigned.
- `rm`  in  3  rounding mode, `FPU_RM_*` encoding (RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100).
- `int_in`  in  32  integer operand.
- `float_out`  out  32  binary32 result `{sgn, exp[7:0], frac[22:0]}`.
- `IE`  out  1  inexact flag.
- `ready`  out  1  one-cycle pulse marking `float_out`/`IE` valid.

## Operation

- Priority at each edge:
  - `kill`, or `load` with neither op bit set: clear both stages, `ready`←0.
  - Otherwise `load` starts a new conversion.
  - Otherwise the pipeline advances.
- Both op bits set simultaneously: treat as `op_cvtif`.
- Stage 1, captured on the `load` edge:
  - `sgn1 = op_cvtif & int_in[31]`.
  - `mag1 = sgn1 ? -int_in : int_in`, taken as 32-bit unsigned. This makes -2^31 give 0x80000000.
  - Also register `rm` and `zero1 = (int_in == 0)`. Set `v1`=1.
- Stage 2, captured on the next edge when `v1`=1 and neither `load` nor `kill` is active:
  - `lz` = leading-zero count of `mag1`, range 0..31 (`mag1`≠0).
  - `norm = mag1 << lz`, so bit 31 = 1.
  - `exp2 = 8'd158 - lz`, where 158 = 127+31.
  - `man2 = norm[31:8]`, 24 bits including the hidden bit.
  - `round2 = norm[7]`, `sticky2 = |norm[6:0]`.
  - Carry `sgn1`, `rm` and `zero1` forward. Set `v2`=1 and `v1`←0.
- A `load` while `v1` or `v2` is set abandons the older operation. Only the newest one ever raises `ready`.
- Output logic (combinational):
  - Round `man2` with `round2`/`sticky2`/`sgn2`/`rm2`:
    - RNE: up if R&(S|L).
    - RTZ: never.
    - RDN: up if `sgn2`&(R|S).
    - RUP: up if !`sgn2`&(R|S).
    - RMM: up if R.
    - Encodings 101–111: behave as RNE.
  - Mantissa carry out of bit 23 sets `exp = exp2+1` and `frac = 0`. The exponent never exceeds 159, so there is no overflow or infinity case.
  - `IE = round2 | sticky2`.
  - Zero input gives `float_out` = 0x00000000 (+0.0 for both ops) and `IE`=0.
  - Invalid, overflow and underflow flags cannot occur and are not provided.
- `float_out`/`IE` are derived only from stage-2 registers. They hold their value after `ready` falls until stage 2 is next overwritten or cleared.

## Timing

- Reset values: every register is 0. Therefore `float_out`=0x00000000, `IE`=0, `ready`=0.
- Latency: `load` sampled at edge k. `ready`=1 for exactly the cycle after edge k+1, i.e. 2 cycles from `load`.
- Back-to-back `load` on consecutive edges: only the last one completes. No `ready` is produced for the others.
- `kill` at edge k+1 suppresses the pending `ready`.
- `n_reset` low at any time clears everything immediately, independent of `clk`.
- Throughput: one conversion per 2 cycles. `load` must not be asserted in the cycle `ready` is expected, unless the team intends to abort the pending conversion.

## Test plan

- Reset asserted mid-conversion (after `load`, before `ready`) → `ready` never pulses; outputs read 0x00000000, `IE`=0.
- `op_cvtif`, `int_in`=1 → 0x3F800000, `IE`=0. Then `int_in`=0xFFFFFFFF → 0xBF800000. Then `int_in`=0x80000000 → 0xCF000000, `IE`=0. Each `ready` arrives exactly 2 cycles after its `load`.
- `op_cvtif`, `int_in`=0x7FFFFFFF → RNE 0x4F000000 `IE`=1; RTZ 0x4EFFFFFF `IE`=1.
- `op_cvtuf`, `int_in`=0x01000001 → RNE 0x4B800000; RUP 0x4B800001; RTZ 0x4B800000; `IE`=1 in all three. Same input with `op_cvtif` and `int_in`=0xFEFFFFFF (−16777217) under RDN → 0xCB800001.
- `op_cvtuf`, `int_in`=0xFFFFFFFF, RNE → 0x4F800000, `IE`=1 (mantissa carry path). `int_in`=0 → 0x00000000, `IE`=0.
- `load` on two consecutive edges (values 1 then 2) → a single `ready` with 0x40000000. Separately, `load` followed by `kill` on the next edge → no `ready`, outputs 0.
